// File: rtl/dds_voice_scheduler.sv
// dds_voice_scheduler
//   Shares one sine lookup ROM among VOICES DDS oscillators. On each accepted
//   sample_tick a frame runs: the voices' phases are issued to the ROM one per
//   cycle, the returned sine values are summed, and the average of the sum is
//   presented as one mixed audio sample.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   sample_tick  one-cycle request for a new mixed sample
//   cfg_we       configuration write strobe
//   cfg_voice    voice selected by the configuration write
//   cfg_incr     phase increment written to that voice
//   cfg_en       enable written to that voice
//   lookup_phase registered phase word driven to the sine ROM
//   sine_value   signed ROM result, valid one cycle after lookup_phase
//   sample_out   signed mixed sample, held between updates
//   sample_valid one-cycle pulse when sample_out updates
//   busy         high while a frame is in progress
//   overrun      sticky: a tick arrived while busy
module dds_voice_scheduler #(
  parameter int VOICES     = 4,
  parameter int DATA_WDTH  = 24,
  parameter int ADDR_WDTH  = 12,
  parameter int CNTR_WDTH  = 4,
  parameter int PHASE_WDTH = ADDR_WDTH + CNTR_WDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sample_tick,
  input  logic                        cfg_we,
  input  logic [$clog2(VOICES)-1:0]   cfg_voice,
  input  logic [PHASE_WDTH-1:0]       cfg_incr,
  input  logic                        cfg_en,
  output logic [PHASE_WDTH-1:0]       lookup_phase,
  input  logic [DATA_WDTH-1:0]        sine_value,
  output logic [DATA_WDTH-1:0]        sample_out,
  output logic                        sample_valid,
  output logic                        busy,
  output logic                        overrun
);

  localparam int VIDX_WDTH = $clog2(VOICES);
  localparam int ACC_WDTH  = DATA_WDTH + VIDX_WDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

  state_t                      state;
  logic [VIDX_WDTH-1:0]        idx;
  logic [PHASE_WDTH-1:0]       cfg_incr_r [VOICES];
  logic [VOICES-1:0]           cfg_en_r;
  logic [PHASE_WDTH-1:0]       act_incr   [VOICES];
  logic [VOICES-1:0]           act_en;
  logic [PHASE_WDTH-1:0]       phase      [VOICES];
  logic signed [ACC_WDTH-1:0]  acc;

  logic [VIDX_WDTH-1:0]        add_voice;
  logic [VIDX_WDTH-1:0]        issue_voice;
  logic signed [ACC_WDTH-1:0]  contrib;
  logic signed [ACC_WDTH-1:0]  acc_next;
  logic signed [ACC_WDTH-1:0]  acc_avg;

  // The ROM answers one cycle after a phase is presented, so the voice whose
  // sine value is on the bus lags the issued voice by one. In DRAIN the index
  // is parked on the last voice, which is the one still returning.
  always_comb begin
    add_voice   = (state == DRAIN) ? idx : idx - VIDX_WDTH'(1);
    issue_voice = idx + VIDX_WDTH'(1);
    contrib     = '0;
    if (act_en[add_voice])
      contrib = {{VIDX_WDTH{sine_value[DATA_WDTH-1]}}, sine_value};
    acc_next = acc + contrib;
    acc_avg  = acc_next >>> VIDX_WDTH;
  end

  // Frame sequencer. Voice 0 is issued on the tick edge itself, straight
  // from the config registers (pre-write values, since the active set is
  // being loaded on the same edge); later voices use the active set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      cfg_en_r     <= '0;
      act_en       <= '0;
      acc          <= '0;
      lookup_phase <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      for (int i = 0; i < VOICES; i++) begin
        cfg_incr_r[i] <= '0;
        act_incr[i]   <= '0;
        phase[i]      <= '0;
      end
    end else begin
      sample_valid <= 1'b0;

      if (cfg_we) begin
        cfg_incr_r[cfg_voice] <= cfg_incr;
        cfg_en_r[cfg_voice]   <= cfg_en;
      end

      if (sample_tick && busy)
        overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (sample_tick) begin
            state        <= ISSUE;
            busy         <= 1'b1;
            idx          <= '0;
            acc          <= '0;
            act_en       <= cfg_en_r;
            for (int i = 0; i < VOICES; i++)
              act_incr[i] <= cfg_incr_r[i];
            lookup_phase <= phase[0];
            phase[0]     <= cfg_en_r[0] ? phase[0] + cfg_incr_r[0] : '0;
          end
        end

        ISSUE: begin
          if (idx != '0)
            acc <= acc_next;
          if (idx == VIDX_WDTH'(VOICES - 1)) begin
            state <= DRAIN;
          end else begin
            idx                 <= issue_voice;
            lookup_phase        <= phase[issue_voice];
            phase[issue_voice]  <= act_en[issue_voice]
                                   ? phase[issue_voice] + act_incr[issue_voice]
                                   : '0;
          end
        end

        // Final add and averaging share one edge so the sample lands in OUT.
        DRAIN: begin
          acc          <= acc_next;
          sample_out   <= acc_avg[DATA_WDTH-1:0];
          sample_valid <= 1'b1;
          state        <= OUT;
        end

        OUT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_voice_scheduler.sv
// tb_dds_voice_scheduler
//   Directed and randomized frames against a frame-level reference model.
module tb_dds_voice_scheduler;

  localparam int VOICES = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_tick;
  logic        cfg_we;
  logic [1:0]  cfg_voice;
  logic [15:0] cfg_incr;
  logic        cfg_en;
  logic [15:0] lookup_phase;
  logic [23:0] sine_value;
  logic [23:0] sample_out;
  logic        sample_valid;
  logic        busy;
  logic        overrun;

  int compared   = 0;
  int mismatched = 0;

  int          rom_mode;
  logic [23:0] rom_const;
  logic [23:0] rom_salt;

  logic [15:0] m_incr  [VOICES];
  logic        m_en    [VOICES];
  logic [15:0] m_phase [VOICES];
  logic        m_overrun;
  logic [23:0] m_sample;
  logic [15:0] obs_look [VOICES];

  dds_voice_scheduler #(.VOICES(4), .DATA_WDTH(24), .ADDR_WDTH(12), .CNTR_WDTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_tick  (sample_tick),
    .cfg_we       (cfg_we),
    .cfg_voice    (cfg_voice),
    .cfg_incr     (cfg_incr),
    .cfg_en       (cfg_en),
    .lookup_phase (lookup_phase),
    .sine_value   (sine_value),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Sine ROM stand-in: constant or a phase-dependent scramble.
  function automatic logic [23:0] rom_fn(input logic [15:0] p);
    if (rom_mode == 0)
      return rom_const;
    return {p[3:0] ^ p[15:12], p, p[11:8]} ^ rom_salt;
  endfunction

  // Registered ROM: answers one cycle after the phase is presented.
  always @(posedge clk)
    sine_value <= rom_fn(lookup_phase);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < VOICES; k++) begin
      m_incr[k]  = '0;
      m_en[k]    = 1'b0;
      m_phase[k] = '0;
    end
    m_overrun = 1'b0;
    m_sample  = '0;
  endtask

  // Called at a negedge in IDLE; returns one cycle later at a negedge.
  task automatic writeCfg(input logic [1:0] v, input logic [15:0] incr, input logic en);
    cfg_we    = 1'b1;
    cfg_voice = v;
    cfg_incr  = incr;
    cfg_en    = en;
    @(negedge clk);
    cfg_we    = 1'b0;
    m_incr[v] = incr;
    m_en[v]   = en;
  endtask

  // One frame. Entered at a negedge (cycle 0), leaves at the negedge of
  // cycle 7, which is the earliest cycle a new tick is accepted.
  // wr_cycle: cycle (0..6) of an optional config write, -1 for none.
  // extra_tick: cycle (1..6) of a tick that must be dropped, -1 for none.
  task automatic applyStimulus(input int wr_cycle, input logic [1:0] wr_v,
                               input logic [15:0] wr_incr, input logic wr_en,
                               input int extra_tick);
    logic [15:0] s_incr [VOICES];
    logic        s_en   [VOICES];
    logic [15:0] exp_look [VOICES];
    int          sum;
    int          avg;
    logic [23:0] prev;
    logic [23:0] nxt;

    for (int k = 0; k < VOICES; k++) begin
      s_incr[k] = m_incr[k];
      s_en[k]   = m_en[k];
    end
    sum = 0;
    for (int k = 0; k < VOICES; k++) begin
      exp_look[k] = m_phase[k];
      if (s_en[k]) begin
        sum        = sum + int'($signed(rom_fn(m_phase[k])));
        m_phase[k] = m_phase[k] + s_incr[k];
      end else begin
        m_phase[k] = '0;
      end
    end
    avg  = sum >>> 2;
    prev = m_sample;
    nxt  = avg[23:0];
    if (wr_cycle >= 0) begin
      m_incr[wr_v] = wr_incr;
      m_en[wr_v]   = wr_en;
    end
    if (extra_tick >= 1)
      m_overrun = 1'b1;

    sample_tick = 1'b1;
    cfg_we      = (wr_cycle == 0);
    cfg_voice   = wr_v;
    cfg_incr    = wr_incr;
    cfg_en      = wr_en;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      sample_tick = (c == extra_tick);
      cfg_we      = (c == wr_cycle);
      if (c <= 4) begin
        obs_look[c-1] = lookup_phase;
        checkOutput($sformatf("lookup_v%0d", c - 1), 32'(lookup_phase), 32'(exp_look[c-1]));
      end
      checkOutput($sformatf("busy_c%0d", c), 32'(busy), 32'(c <= 6));
      checkOutput($sformatf("valid_c%0d", c), 32'(sample_valid), 32'(c == 6));
      checkOutput($sformatf("sample_c%0d", c), 32'(sample_out), 32'((c >= 6) ? nxt : prev));
    end
    checkOutput("overrun", 32'(overrun), 32'(m_overrun));
    m_sample = nxt;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++)
      @(negedge clk);
  endtask

  initial begin
    logic [15:0] look_a;
    logic [31:0] r;
    int          wc;
    int          et;

    rst_n       = 1'b0;
    sample_tick = 1'b0;
    cfg_we      = 1'b0;
    cfg_voice   = '0;
    cfg_incr    = '0;
    cfg_en      = 1'b0;
    rom_mode    = 0;
    rom_const   = '0;
    r           = $urandom;
    rom_salt    = r[23:0];
    modelReset();

    $display("[TB] reset state");
    idleCycles(3);
    checkOutput("rst_lookup", 32'(lookup_phase), 32'h0);
    checkOutput("rst_sample", 32'(sample_out), 32'h0);
    checkOutput("rst_valid", 32'(sample_valid), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single voice");
    rom_mode = 1;
    writeCfg(2'd0, 16'h0100, 1'b1);
    applyStimulus(-1, 2'd0, 16'h0, 1'b0, -1);
    checkOutput("sv_f0_v0", 32'(obs_look[0]), 32'h0000);
    checkOutput("sv_f0_v1", 32'(obs_look[1]), 32'h0000);
    idleCycles(13);
    applyStimulus(-1, 2'd0, 16'h0, 1'b0, -1);
    checkOutput("sv_f1_v0", 32'(obs_look[0]), 32'h0100);
    idleCycles(13);
    applyStimulus(-1, 2'd0, 16'h0, 1'b0, -1);
    checkOutput("sv_f2_v0", 32'(obs_look[0]), 32'h0200);
    checkOutput("sv_f2_v3", 32'(obs_look[3]), 32'h0000);

    $display("[TB] mix arithmetic");
    rom_mode  = 0;
    rom_const = 24'h400000;
    writeCfg(2'd1, 16'h0123, 1'b1);
    writeCfg(2'd2, 16'h0456, 1'b1);
    writeCfg(2'd3, 16'h0789, 1'b1);
    applyStimulus(-1, 2'd0, 16'h0, 1'b0, -1);
    checkOutput("mix_all_pos", 32'(sample_out), 32'h400000);
    writeCfg(2'd2, 16'h0456, 1'b0);
    writeCfg(2'd3, 16'h0789, 1'b0);
    applyStimulus(-1, 2'd0, 16'h0, 1'b0, -1);
    checkOutput("mix_two_pos", 32'(sample_out), 32'h200000);
    rom_const = 24'hC00000;
    writeCfg(2'd2, 16'h0456, 1'b1);
    writeCfg(2'd3, 16'h0789, 1'b1);
    applyStimulus(-1, 2'd0, 16'h0, 1'b0, -1);
    checkOutput("mix_all_neg", 32'(sample_out), 32'hC00000);

    $display("[TB] phase wrap");
    rom_mode = 1;
    writeCfg(2'd0, 16'h8000, 1'b0);
    applyStimulus(-1, 2'd0, 16'h0, 1'b0, -1);
    writeCfg(2'd0, 16'h8000, 1'b1);
    applyStimulus(-1, 2'd0, 16'h0, 1'b0, -1);
    checkOutput("wrap_f0", 32'(obs_look[0]), 32'h0000);
    applyStimulus(-1, 2'd0, 16'h0, 1'b0, -1);
    checkOutput("wrap_f1", 32'(obs_look[0]), 32'h8000);
    applyStimulus(-1, 2'd0, 16'h0, 1'b0, -1);
    checkOutput("wrap_f2", 32'(obs_look[0]), 32'h0000);

    $display("[TB] overrun");
    applyStimulus(-1, 2'd0, 16'h0, 1'b0, 3);
    checkOutput("ovr_set", 32'(overrun), 32'h1);
    applyStimulus(-1, 2'd0, 16'h0, 1'b0, -1);
    checkOutput("ovr_phase", 32'(obs_look[0]), 32'h0000);
    checkOutput("ovr_sticky", 32'(overrun), 32'h1);

    $display("[TB] config during busy");
    writeCfg(2'd0, 16'h0100, 1'b1);
    applyStimulus(2, 2'd0, 16'h0200, 1'b1, -1);
    look_a = obs_look[0];
    applyStimulus(-1, 2'd0, 16'h0, 1'b0, -1);
    checkOutput("busy_cfg_old", 32'(obs_look[0] - look_a), 32'h0100);
    applyStimulus(-1, 2'd0, 16'h0, 1'b0, -1);
    checkOutput("busy_cfg_new", 32'(obs_look[0] - look_a), 32'h0300);
    applyStimulus(2, 2'd0, 16'h0200, 1'b0, -1);
    applyStimulus(-1, 2'd0, 16'h0, 1'b0, -1);
    applyStimulus(-1, 2'd0, 16'h0, 1'b0, -1);
    checkOutput("busy_cfg_dis", 32'(obs_look[0]), 32'h0000);
    applyStimulus(0, 2'd0, 16'h0040, 1'b1, -1);
    applyStimulus(-1, 2'd0, 16'h0, 1'b0, -1);
    checkOutput("tick_cfg_same", 32'(obs_look[0]), 32'h0000);

    $display("[TB] randomized frames");
    for (int f = 0; f < 40; f++) begin
      for (int w = 0; w < $urandom_range(0, 2); w++) begin
        r = $urandom;
        writeCfg(r[1:0], r[17:2], r[31] | r[30]);
      end
      rom_mode  = $urandom_range(0, 1);
      r         = $urandom;
      rom_const = r[23:0];
      idleCycles($urandom_range(0, 3));
      wc = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, 6);
      et = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : -1;
      r  = $urandom;
      applyStimulus(wc, r[1:0], r[17:2], r[31], et);
    end

    $display("[TB] reset mid-frame");
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    idleCycles(2);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mrst_lookup", 32'(lookup_phase), 32'h0);
    checkOutput("mrst_sample", 32'(sample_out), 32'h0);
    checkOutput("mrst_valid", 32'(sample_valid), 32'h0);
    checkOutput("mrst_busy", 32'(busy), 32'h0);
    checkOutput("mrst_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    modelReset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput($sformatf("mrst_novalid_%0d", c), 32'(sample_valid), 32'h0);
    end
    rom_mode = 1;
    writeCfg(2'd0, 16'h0ABC, 1'b1);
    applyStimulus(-1, 2'd0, 16'h0, 1'b0, -1);
    checkOutput("mrst_phase0", 32'(obs_look[0]), 32'h0000);
    applyStimulus(-1, 2'd0, 16'h0, 1'b0, -1);
    checkOutput("mrst_phase1", 32'(obs_look[0]), 32'h0ABC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dds_voice_scheduler.md
# dds_voice_scheduler

Time-multiplexes one shared sine lookup ROM across VOICES independent DDS oscillators and mixes them into one audio sample per sample tick. It owns each voice's phase accumulator and increment, sequences the lookups into the ROM, and accumulates the returned values into a scaled mix. It sits between the sample-rate timing source and the audio output path, and drives the sine ROM's phase input.

## Interface
- VOICES, 4: number of oscillators; power of 2, at least 2.
- DATA_WDTH, 24: signed sample width; matches the ROM output.
- ADDR_WDTH, 12: ROM address width, including the 2 quadrant bits.
- CNTR_WDTH, 4: fractional phase bits.
- PHASE_WDTH, ADDR_WDTH+CNTR_WDTH: width of the phase accumulator and the lookup word.

Ports:
- clk  in  1  the single clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- sample_tick  in  1  one-cycle pulse that requests one mixed sample.
- cfg_we  in  1  configuration write strobe.
- cfg_voice  in  clog2(VOICES)  voice index for the write.
- cfg_incr  in  PHASE_WDTH  phase increment written to that voice.
- cfg_en  in  1  enable written to that voice.
- lookup_phase  out  PHASE_WDTH  registered phase word to the ROM.
- sine_value  in  DATA_WDTH  signed ROM result; valid one cycle after lookup_phase is presented.
- sample_out  out  DATA_WDTH  signed mixed sample; held between updates.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- busy  out  1  high while a frame is in progress.
- overrun  out  1  sticky flag: a tick arrived while busy.

## Operation
- **Config registers.** Each voice has a config pair: incr and en. A write with cfg_we=1 updates the pair for cfg_voice on that edge.
- **Frame start.** Config pairs are copied into an active set when a frame starts. A write made during a frame therefore takes effect on the next frame.
- **Frame state machine.** States are IDLE, ISSUE, DRAIN and OUT.
  - IDLE → ISSUE on sample_tick=1. This edge snapshots the config and clears the mix accumulator.
  - ISSUE runs for VOICES cycles, issuing voice k in the k-th ISSUE cycle, then → DRAIN.
  - DRAIN lasts one cycle, then → OUT.
  - OUT lasts one cycle, then → IDLE.
- **Issue, voice k.**
  - lookup_phase = phase[k], taken before this frame's increment.
  - Enabled voice: phase[k] ← phase[k] + incr[k], modulo 2^PHASE_WDTH with silent wrap.
  - Disabled voice: phase[k] ← 0 and its contribution is forced to 0. A voice being enabled therefore always starts at phase 0.
- **Mix.**
  - sine_value for voice k is added, sign-extended, into a DATA_WDTH+clog2(VOICES)-bit signed accumulator during the cycle after voice k is issued.
  - The last add happens in DRAIN.
  - In OUT: sample_out ← accumulator >>> clog2(VOICES) (arithmetic shift, truncation toward −∞) and sample_valid=1. The average cannot overflow.
- **busy** is high in ISSUE, DRAIN and OUT. It is low only in IDLE.
- **Overrun.** A sample_tick while busy=1 is dropped: the phase is not advanced and no extra sample is produced. It sets overrun, which stays high until reset.
- **Simultaneous events.** If sample_tick and cfg_we coincide in IDLE, the snapshot takes the register value from before the write; the write affects the following frame.
- **Reset.** Reset in any state returns to IDLE and clears all of the following to 0: phase, incr, en, active set, accumulator, lookup_phase, sample_out, sample_valid, busy and overrun. An interrupted frame produces no sample_valid.

## Timing
- Cycle 0 is the cycle in which sample_tick=1 is sampled in IDLE.
- lookup_phase carries voice k during cycle k+1, for k = 0..VOICES−1.
- sine_value for voice k is captured at the end of cycle k+2.
- sample_valid=1 and the new sample_out appear in cycle VOICES+2. For VOICES=4 that is cycle 6.
- busy=1 in cycles 1..VOICES+2.
- The earliest accepted next tick is cycle VOICES+3. The minimum tick spacing is therefore VOICES+3 cycles.
- lookup_phase holds its last value outside ISSUE.

## Test plan
- **Reset.** Assert rst_n=0 mid-frame (cycle 3), release → all outputs 0, no sample_valid, next tick gives a normal frame with phases starting at 0.
- **Single voice.** VOICES=4, voice 0 en=1, incr=0x0100; three ticks 20 cycles apart → voice-0 lookup_phase in cycle 1 of each frame is 0x0000, 0x0100, 0x0200; voices 1–3 present 0x0000.
- **Mix arithmetic (constant ROM model).**
  - ROM returns 0x400000 for every lookup, all 4 voices enabled → sample_out=0x400000 in cycle 6.
  - Same ROM, voices 0 and 1 enabled → 0x200000.
  - ROM returns 0xC00000, all 4 voices enabled → 0xC00000.
- **Wrap.** incr=0x8000 → successive voice-0 phases are 0x0000, 0x8000, 0x0000.
- **Overrun.** A second tick at cycle 3 → overrun=1 and stays high, exactly one sample_valid, voice-0 phase advanced once.
- **Config during busy.** Write incr=0x0200 to voice 0 at cycle 2 of a frame where incr was 0x0100 → the current frame still adds 0x0100; the next frame adds 0x0200. Disabling voice 0 → its phase is 0 at the following frame.
